instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: receives a program as a big-endian byte stream over a valid/ready handshake.
- Assembles each group of 4 bytes into a 32-bit instruction word and issues one write per word to a writable instruction-memory port.
- Write addresses are byte addresses, 0, 4, 8, ..., so the read side's word index (address >> 2) lines up.
- Holds the MIPS core in reset while loading; reports completion or error.

Parameters:
- INST_WIDTH, 32, instruction word width (fixed at 4 bytes).
- INST_ADD_WIDTH, 32, width of the instruction byte address.
- INST_MEM_DEPTH, 100, number of instruction words in memory.
- CNT_WIDTH, 8, width of Word_Count.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- Load_Start  in  1  one-cycle start request.
- Word_Count  in  CNT_WIDTH  number of words to load; sampled with Load_Start.
- Byte_In  in  8  stream byte.
- Byte_Valid  in  1  Byte_In is valid.
- Byte_Ready  out  1  loader accepts a byte this cycle.
- Mem_WE  out  1  instruction-memory write enable.
- Mem_WAdd  out  INST_ADD_WIDTH  byte write address (always a multiple of 4).
- Mem_WD  out  INST_WIDTH  write data.
- CPU_Hold  out  1  keeps the core in reset while high.
- Load_Done  out  1  sticky: load completed.
- Load_Err  out  1  sticky: load rejected or failed.

Behaviour:
- Reset: state IDLE. Byte_Ready, Mem_WE, CPU_Hold, Load_Done, Load_Err all 0. Mem_WAdd=0, Mem_WD=0. Internal word index and byte count = 0.
- RST has priority over all inputs and aborts any load mid-operation.
- A reset during a load does not undo writes already performed.
- A byte transfer occurs only when Byte_Valid & Byte_Ready are both high in the same cycle.
- IDLE / DONE / ERR, on Load_Start:
  - Word_Count==0 or Word_Count>INST_MEM_DEPTH: go to ERR; Load_Err=1, Load_Done=0, CPU_Hold=0.
  - Otherwise: latch the count, clear word index and byte count, clear Load_Done and Load_Err, set CPU_Hold=1, go to RECV.
- RECV:
  - Byte_Ready=1.
  - Each transfer: Mem_WD <= {Mem_WD[23:0], Byte_In}, so the first byte lands in the MSB.
  - Byte count increments; on the 4th transfer, go to WRITE.
  - Byte_Valid low simply stalls; no timeout.
- WRITE (exactly 1 cycle):
  - Byte_Ready=0, Mem_WE=1, Mem_WAdd = word index × 4, Mem_WD holds the assembled word.
  - Next cycle: word index +1, byte count cleared.
  - If this was the last word (index == count−1), go to DONE; else back to RECV.
- DONE: Load_Done=1, CPU_Hold=0, Byte_Ready=0; stays until the next Load_Start.
- ERR: Load_Err=1, CPU_Hold=0; stays until the next Load_Start.
- Load_Start while in RECV or WRITE is ignored.
- Mem_WE is high only in WRITE. Mem_WAdd/Mem_WD are don't-care when Mem_WE=0 but must not contain X after reset.
- Throughput: minimum 5 cycles per word (4 byte cycles + 1 write cycle).
- Load_Done rises the cycle after the last Mem_WE pulse.
- Mem_WAdd never exceeds (INST_MEM_DEPTH−1)×4.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last word's WRITE, go to state CSUM with Byte_Ready=1 and accept one extra checksum byte.
  - The 8-bit wrap-around sum of all data bytes plus the checksum byte must equal 0x00.
  - Match: go to DONE. Mismatch: go to ERR (Load_Err=1); memory writes are not rolled back.
  - CPU_Hold stays 1 until the checksum byte is accepted.
- Not defined: no CSUM state, no checksum byte; Load_Err is raised only for a bad Word_Count.

Test Plan:
- Reset, then Load_Start with Word_Count=2 and bytes 20 08 00 05 8C 09 00 04 (valid every cycle) -> Mem_WE pulses (0x0, 0x20080005) then (0x4, 0x8C090004); Load_Done=1 one cycle later; CPU_Hold high from the cycle after Load_Start until DONE.
- Same load with Byte_Valid low for 3 cycles between each byte -> identical writes and data; no extra Mem_WE pulses; Byte_Ready stays 1 in RECV.
- Word_Count=0, then Word_Count=101 -> ERR with Load_Err=1, no Mem_WE, CPU_Hold=0; a following valid Load_Start clears Load_Err.
- Load_Start pulsed after 2 bytes of word 1 -> ignored; the load completes normally with 2 writes.
- RST asserted after the first write of a 3-word load -> all outputs return to reset values next cycle; a new load starts cleanly at address 0.
- LOADER_CHECKSUM_EN: Word_Count=1, bytes 01 02 03 04 then checksum F6 -> Load_Done. Repeating with checksum F7 -> Load_Err=1, with the write to address 0 of 0x01020304 still performed.

Source files
------------

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Writer side of the instruction memory. Receives a program as a big-endian
//   byte stream (valid/ready), packs every 4 bytes into one instruction word
//   and writes it to byte address 0, 4, 8, ... The MIPS core is held in reset
//   while a load is in progress.
//
// Ports
//   CLK, RST      rising-edge clock, synchronous active-high reset
//   Load_Start    one-cycle start request (ignored while a load is running)
//   Word_Count    words to load, sampled with Load_Start (1..INST_MEM_DEPTH)
//   Byte_In       stream byte, transferred when Byte_Valid & Byte_Ready
//   Byte_Valid    Byte_In is valid
//   Byte_Ready    loader accepts a byte this cycle
//   Mem_WE        instruction-memory write enable (one cycle per word)
//   Mem_WAdd      byte write address, always a multiple of 4
//   Mem_WD        assembled write data (first byte in the MSB)
//   CPU_Hold      keeps the core in reset while high
//   Load_Done     load completed (held until the next Load_Start)
//   Load_Err      load rejected or failed (held until the next Load_Start)
//
// Build option
//   LOADER_CHECKSUM_EN  when defined, one checksum byte follows the last word;
//                       the 8-bit sum of all data bytes plus the checksum byte
//                       must be 0x00, otherwise the load ends in error.
// ---------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int INST_WIDTH     = 32,
    parameter int INST_ADD_WIDTH = 32,
    parameter int INST_MEM_DEPTH = 100,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Load_Start,
    input  logic [CNT_WIDTH-1:0]      Word_Count,
    input  logic [7:0]                Byte_In,
    input  logic                      Byte_Valid,
    output logic                      Byte_Ready,
    output logic                      Mem_WE,
    output logic [INST_ADD_WIDTH-1:0] Mem_WAdd,
    output logic [INST_WIDTH-1:0]     Mem_WD,
    output logic                      CPU_Hold,
    output logic                      Load_Done,
    output logic                      Load_Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [CNT_WIDTH-1:0] cnt_lat;
    logic [CNT_WIDTH-1:0] word_idx;
    logic [1:0]           byte_cnt;
    logic                 xfer;
    logic                 count_ok;
    logic                 last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           csum;
    logic [7:0]           csum_fin;
    assign csum_fin = csum + Byte_In;
`endif

    assign xfer      = Byte_Valid & Byte_Ready;
    assign count_ok  = (Word_Count != '0) &&
                       (32'(Word_Count) <= 32'(INST_MEM_DEPTH));
    assign last_word = (word_idx == cnt_lat - CNT_WIDTH'(1));

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (Load_Start) begin
                    state_nxt = count_ok ? S_RECV : S_ERR;
                end
            end
            S_RECV: begin
                if (xfer && (byte_cnt == 2'd3)) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_nxt = (csum_fin == 8'h00) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: all control outputs are decoded from the state, so Load_Done
    // and Load_Err stay up exactly as long as DONE/ERR is held.
    always_comb begin
        Byte_Ready = 1'b0;
        Mem_WE     = 1'b0;
        CPU_Hold   = 1'b0;
        Load_Done  = 1'b0;
        Load_Err   = 1'b0;
        Mem_WAdd   = INST_ADD_WIDTH'({word_idx, 2'b00});
        unique case (state)
            S_RECV: begin
                Byte_Ready = 1'b1;
                CPU_Hold   = 1'b1;
            end
            S_WRITE: begin
                Mem_WE   = 1'b1;
                CPU_Hold = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                Byte_Ready = 1'b1;
                CPU_Hold   = 1'b1;
            end
`endif
            S_DONE:  Load_Done = 1'b1;
            S_ERR:   Load_Err  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: word assembly, indices and checksum accumulation.
    // The word index is not advanced past the last word, so Mem_WAdd never
    // points beyond the final memory location.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_lat  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            Mem_WD   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (Load_Start && count_ok) begin
                        cnt_lat  <= Word_Count;
                        word_idx <= '0;
                        byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        Mem_WD   <= {Mem_WD[INST_WIDTH-9:0], Byte_In};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum + Byte_In;
`endif
                    end
                end
                S_WRITE: begin
                    byte_cnt <= '0;
                    if (!last_word) begin
                        word_idx <= word_idx + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int DEPTH = 100;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Load_Start;
    logic [7:0]  Word_Count;
    logic [7:0]  Byte_In;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic        Mem_WE;
    logic [31:0] Mem_WAdd;
    logic [31:0] Mem_WD;
    logic        CPU_Hold;
    logic        Load_Done;
    logic        Load_Err;

    always #5 CLK = ~CLK;

    instr_mem_loader #(
        .INST_WIDTH    (32),
        .INST_ADD_WIDTH(32),
        .INST_MEM_DEPTH(DEPTH),
        .CNT_WIDTH     (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Load_Start(Load_Start),
        .Word_Count(Word_Count),
        .Byte_In   (Byte_In),
        .Byte_Valid(Byte_Valid),
        .Byte_Ready(Byte_Ready),
        .Mem_WE    (Mem_WE),
        .Mem_WAdd  (Mem_WAdd),
        .Mem_WD    (Mem_WD),
        .CPU_Hold  (CPU_Hold),
        .Load_Done (Load_Done),
        .Load_Err  (Load_Err)
    );

`ifdef LOADER_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every Mem_WE pulse and the Load_Done rising cycle.
    int          cyc = 0;
    int          wr_n = 0;
    logic [31:0] wr_addr [0:511];
    logic [31:0] wr_data [0:511];
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    logic        prev_done = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Mem_WE === 1'b1) begin
            if (wr_n < 512) begin
                wr_addr[wr_n] = Mem_WAdd;
                wr_data[wr_n] = Mem_WD;
            end
            wr_n++;
            last_we_cyc = cyc;
        end
        if (Load_Done === 1'b1 && !prev_done) done_cyc = cyc;
        prev_done = (Load_Done === 1'b1);
    end

    // Program image fed by the next load (model input).
    logic [7:0] stim [0:511];

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, Byte_Ready, 0);
        check_eq({tag, "_we"},    Mem_WE,     0);
        check_eq({tag, "_hold"},  CPU_Hold,   0);
        check_eq({tag, "_done"},  Load_Done,  0);
        check_eq({tag, "_err"},   Load_Err,   0);
        check_eq({tag, "_wadd"},  Mem_WAdd,   0);
        check_eq({tag, "_wd"},    Mem_WD,     0);
    endtask

    // gap_mode: 0 = valid every cycle, >0 = that many idle cycles before each
    // byte, <0 = random 0..3. bad_cs sends a wrong checksum byte.
    // abort_after > 0 asserts RST once that many writes have been seen.
    task automatic run_load(input int cnt, input int gap_mode, input bit glitch,
                            input bit bad_cs, input int abort_after);
        int         total;
        int         gap;
        int         waited;
        logic [7:0] sum;
        logic [7:0] b;
        bit         exp_ok;
        total = cnt * 4;
        sum   = 8'h00;
        wr_n  = 0;
        Word_Count = 8'(cnt);
        Load_Start = 1'b1;
        @(negedge CLK);
        Load_Start = 1'b0;
        Word_Count = 8'($urandom);
        check_eq("start_hold", CPU_Hold, 1);
        check_eq("start_ready", Byte_Ready, 1);
        check_eq("start_done_clr", Load_Done, 0);
        check_eq("start_err_clr", Load_Err, 0);
        for (int i = 0; i < total + CSUM_BYTES; i++) begin
            if (i < total) begin
                b   = stim[i];
                sum = sum + b;
            end else begin
                b = ~sum + 8'd1 + (bad_cs ? 8'd1 : 8'd0);
            end
            gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
            for (int g = 0; g < gap; g++) begin
                Byte_Valid = 1'b0;
                Byte_In    = 8'($urandom);
                if ((i % 4) != 0 && i < total) check_eq("stall_ready", Byte_Ready, 1);
                @(negedge CLK);
            end
            Byte_Valid = 1'b1;
            Byte_In    = b;
            waited     = 0;
            while (Byte_Ready !== 1'b1 && waited < 8) begin
                @(negedge CLK);
                waited++;
            end
            if (waited >= 8) begin
                check_eq("ready_timeout", 0, 1);
                break;
            end
            check_eq("load_hold", CPU_Hold, 1);
            if (glitch && i == 2) begin
                Load_Start = 1'b1;
                Word_Count = 8'd0;
            end
            @(negedge CLK);
            Load_Start = 1'b0;
            if (abort_after > 0 && wr_n >= abort_after) begin
                Byte_Valid = 1'b0;
                RST = 1'b1;
                @(negedge CLK);
                check_reset_outputs("abort");
                RST = 1'b0;
                return;
            end
        end
        Byte_Valid = 1'b0;
        waited = 0;
        while (Load_Done !== 1'b1 && Load_Err !== 1'b1 && waited < 12) begin
            @(negedge CLK);
            waited++;
        end
        exp_ok = (CSUM_BYTES == 0) || !bad_cs;
        check_eq("end_done", Load_Done, exp_ok);
        check_eq("end_err", Load_Err, !exp_ok);
        check_eq("end_hold", CPU_Hold, 0);
        check_eq("end_ready", Byte_Ready, 0);
        repeat (3) @(negedge CLK);
        check_eq("sticky", {Load_Done, Load_Err}, {exp_ok, !exp_ok});
        check_eq("wr_count", wr_n, cnt);
        for (int k = 0; k < cnt && k < wr_n; k++) begin
            check_eq("wr_addr", wr_addr[k], 32'(k * 4));
            check_eq("wr_data", wr_data[k],
                     {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]});
        end
        if (CSUM_BYTES == 0) check_eq("done_latency", done_cyc - last_we_cyc, 1);
    endtask

    task automatic bad_start(input int cnt);
        wr_n = 0;
        Word_Count = 8'(cnt);
        Load_Start = 1'b1;
        @(negedge CLK);
        Load_Start = 1'b0;
        check_eq("bad_err", Load_Err, 1);
        check_eq("bad_done", Load_Done, 0);
        check_eq("bad_hold", CPU_Hold, 0);
        check_eq("bad_ready", Byte_Ready, 0);
        Byte_Valid = 1'b1;
        Byte_In    = 8'($urandom);
        repeat (6) @(negedge CLK);
        Byte_Valid = 1'b0;
        check_eq("bad_no_write", wr_n, 0);
        check_eq("bad_err_sticky", Load_Err, 1);
    endtask

    task automatic fill_random(input int nbytes);
        for (int i = 0; i < nbytes; i++) stim[i] = 8'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prog [0:7];
        int         cnt;
        RST        = 1'b1;
        Load_Start = 1'b0;
        Word_Count = 8'd0;
        Byte_In    = 8'd0;
        Byte_Valid = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        for (int i = 0; i < 8; i++) stim[i] = prog[i];
        run_load(2, 0, 1'b0, 1'b0, 0);
        run_load(2, 3, 1'b0, 1'b0, 0);

        bad_start(0);
        bad_start(101);
        bad_start(255);
        fill_random(8);
        run_load(2, 0, 1'b0, 1'b0, 0);

        fill_random(8);
        run_load(2, 0, 1'b1, 1'b0, 0);

        fill_random(12);
        run_load(3, 0, 1'b0, 1'b0, 1);
        fill_random(12);
        run_load(3, -1, 1'b0, 1'b0, 0);

`ifdef LOADER_CHECKSUM_EN
        for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
        run_load(1, 0, 1'b0, 1'b0, 0);
        run_load(1, 0, 1'b0, 1'b1, 0);
`endif

        fill_random(4 * DEPTH);
        run_load(DEPTH, 0, 1'b0, 1'b0, 0);
        fill_random(4);
        run_load(1, -1, 1'b0, 1'b0, 0);

        for (int t = 0; t < 20; t++) begin
            cnt = int'($urandom_range(1, 6));
            fill_random(4 * cnt);
            run_load(cnt, -1, 1'b0, bit'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
